// File: rtl/convolution_processor_datapath.sv
// convolution_processor_datapath
// Addressing and arithmetic datapath behind the convolution processor FSM.
// Computes z[h] = sum_j y[j] * x[h-j] for 0 <= h < size_z, where
// size_z = size_x + size_y - 1 (0 when either size is 0).
// Holds the output counter h, the tap counter j, the accumulator, and the
// staged output sample. It also returns the three flags that steer the FSM.
// Optional build macro: CONV_DP_SAT_EN
//   defined   -> out_z_i saturates the accumulator to 2^Z_W-1
//   undefined -> out_z_i truncates the accumulator to Z_W bits
module convolution_processor_datapath #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5,
    parameter int Z_W    = 16
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              init_i,
    input  logic              clr_i,
    input  logic              shift_i,
    input  logic              convo_i,
    input  logic              count_y_i,
    input  logic              out_z_i,
    input  logic              writez_i,
    input  logic              count_h_i,
    input  logic [ADDR_W-1:0] size_x_i,
    input  logic [ADDR_W-1:0] size_y_i,
    output logic              comp_hz_o,
    output logic              comp_yy_o,
    output logic              comp_shift_o,
    output logic [ADDR_W-1:0] memx_addr_o,
    input  logic [DATA_W-1:0] memx_data_i,
    output logic [ADDR_W-1:0] memy_addr_o,
    input  logic [DATA_W-1:0] memy_data_i,
    output logic [ADDR_W:0]   memz_addr_o,
    output logic [Z_W-1:0]    memz_data_o,
    output logic              memz_we_o
);

    // Counters are one bit wider than the X/Y addresses so that they can
    // hold size_z and can reach the terminal values without wrapping.
    localparam int HW    = ADDR_W + 1;
    localparam int PW    = 2 * DATA_W;
    localparam int ACC_W = 2 * DATA_W + ADDR_W + 1;

    localparam logic [ACC_W-1:0] Z_MAX = {{(ACC_W-Z_W){1'b0}}, {Z_W{1'b1}}};

    logic [ADDR_W-1:0] size_x_r;
    logic [ADDR_W-1:0] size_y_r;
    logic [HW-1:0]     size_z_r;
    logic [HW-1:0]     h_r;
    logic [HW-1:0]     j_r;
    logic [ACC_W-1:0]  acc_r;
    logic [Z_W-1:0]    z_r;
    logic [ADDR_W-1:0] memx_addr_r;
    logic [ADDR_W-1:0] memy_addr_r;
    logic              shift_ok_r;

    logic [HW-1:0]     size_z_s;
    logic [HW-1:0]     diff_s;
    logic              shift_ok_s;
    logic [PW-1:0]     prod_s;
    logic [ACC_W-1:0]  acc_sum_s;
    logic [Z_W-1:0]    z_next_s;
    logic              write_s;

    // Output length from the sizes presented with init; an empty operand gives an empty result.
    always_comb begin
        size_z_s = {HW{1'b0}};
        if ((size_x_i == {ADDR_W{1'b0}}) || (size_y_i == {ADDR_W{1'b0}})) begin
            size_z_s = {HW{1'b0}};
        end else begin
            size_z_s = {1'b0, size_x_i} + {1'b0, size_y_i} - HW'(1);
        end
    end

    // Tap validity: x[h-j] exists only when h >= j and h-j is inside the X buffer.
    always_comb begin
        diff_s     = h_r - j_r;
        shift_ok_s = 1'b0;
        if (h_r >= j_r) begin
            shift_ok_s = (diff_s < {1'b0, size_x_r});
        end else begin
            shift_ok_s = 1'b0;
        end
    end

    // Full-width product and the next accumulator value.
    always_comb begin
        prod_s    = PW'(memx_data_i) * PW'(memy_data_i);
        acc_sum_s = acc_r + ACC_W'(prod_s);
    end

    // Reduction of the accumulator to the Z sample width.
    always_comb begin
        z_next_s = {Z_W{1'b0}};
`ifdef CONV_DP_SAT_EN
        if (acc_r > Z_MAX) begin
            z_next_s = Z_MAX[Z_W-1:0];
        end else begin
            z_next_s = acc_r[Z_W-1:0];
        end
`else
        if (acc_r > Z_MAX) begin
            z_next_s = acc_r[Z_W-1:0];
        end else begin
            z_next_s = acc_r[Z_W-1:0];
        end
`endif
    end

    // Datapath state: init wins over clr, and clr wins over the j/acc updates; the other strobes act together.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            size_x_r    <= {ADDR_W{1'b0}};
            size_y_r    <= {ADDR_W{1'b0}};
            size_z_r    <= {HW{1'b0}};
            h_r         <= {HW{1'b0}};
            j_r         <= {HW{1'b0}};
            acc_r       <= {ACC_W{1'b0}};
            z_r         <= {Z_W{1'b0}};
            memx_addr_r <= {ADDR_W{1'b0}};
            memy_addr_r <= {ADDR_W{1'b0}};
            shift_ok_r  <= 1'b0;
        end else if (init_i) begin
            size_x_r   <= size_x_i;
            size_y_r   <= size_y_i;
            size_z_r   <= size_z_s;
            h_r        <= {HW{1'b0}};
            j_r        <= {HW{1'b0}};
            acc_r      <= {ACC_W{1'b0}};
            z_r        <= {Z_W{1'b0}};
            shift_ok_r <= 1'b0;
        end else begin
            if (clr_i) begin
                j_r   <= {HW{1'b0}};
                acc_r <= {ACC_W{1'b0}};
            end else begin
                if (count_y_i) begin
                    j_r <= j_r + HW'(1);
                end
                if (convo_i) begin
                    acc_r <= acc_sum_s;
                end
            end
            if (shift_i) begin
                memy_addr_r <= j_r[ADDR_W-1:0];
                memx_addr_r <= diff_s[ADDR_W-1:0];
                shift_ok_r  <= shift_ok_s;
            end
            if (out_z_i) begin
                z_r <= z_next_s;
            end
            if (count_h_i) begin
                h_r <= h_r + HW'(1);
            end
        end
    end

    // Z write port follows writez_i in the same cycle; reset removes a write in flight at once.
    always_comb begin
        write_s = writez_i & rstn;
        if (write_s) begin
            memz_we_o   = 1'b1;
            memz_addr_o = h_r;
            memz_data_o = z_r;
        end else begin
            memz_we_o   = 1'b0;
            memz_addr_o = {HW{1'b0}};
            memz_data_o = {Z_W{1'b0}};
        end
    end

    // Steering flags and read addresses, all taken straight from registers.
    always_comb begin
        comp_hz_o    = (h_r < size_z_r);
        comp_yy_o    = (j_r < {1'b0, size_y_r});
        comp_shift_o = shift_ok_r;
        memx_addr_o  = memx_addr_r;
        memy_addr_o  = memy_addr_r;
    end

endmodule

// File: tb/tb_convolution_processor_datapath.sv
// Directed bench for convolution_processor_datapath with a write scoreboard.
// The sequencer mimics the FSM; expected Z writes are queued up front and a
// monitor on the falling edge pops and compares every asserted write.
module tb_convolution_processor_datapath;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 5;
    localparam int Z_W    = 16;

    logic              clk = 1'b0;
    logic              rstn;
    logic              init_i, clr_i, shift_i, convo_i;
    logic              count_y_i, out_z_i, writez_i, count_h_i;
    logic [ADDR_W-1:0] size_x_i, size_y_i;
    logic              comp_hz_o, comp_yy_o, comp_shift_o;
    logic [ADDR_W-1:0] memx_addr_o, memy_addr_o;
    logic [DATA_W-1:0] memx_data_i, memy_data_i;
    logic [ADDR_W:0]   memz_addr_o;
    logic [Z_W-1:0]    memz_data_o;
    logic              memz_we_o;

    logic [DATA_W-1:0] x_mem [0:31];
    logic [DATA_W-1:0] y_mem [0:31];

    logic [ADDR_W+Z_W:0] exp_q [$];

    int n_vec = 0;
    int n_err = 0;

    convolution_processor_datapath #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .Z_W(Z_W)
    ) dut (
        .clk(clk), .rstn(rstn),
        .init_i(init_i), .clr_i(clr_i), .shift_i(shift_i), .convo_i(convo_i),
        .count_y_i(count_y_i), .out_z_i(out_z_i), .writez_i(writez_i), .count_h_i(count_h_i),
        .size_x_i(size_x_i), .size_y_i(size_y_i),
        .comp_hz_o(comp_hz_o), .comp_yy_o(comp_yy_o), .comp_shift_o(comp_shift_o),
        .memx_addr_o(memx_addr_o), .memx_data_i(memx_data_i),
        .memy_addr_o(memy_addr_o), .memy_data_i(memy_data_i),
        .memz_addr_o(memz_addr_o), .memz_data_o(memz_data_o), .memz_we_o(memz_we_o)
    );

    always #5 clk = ~clk;

    // Synchronous X/Y memories with one cycle of read latency.
    always @(posedge clk) begin
        memx_data_i <= x_mem[memx_addr_o];
        memy_data_i <= y_mem[memy_addr_o];
    end

    // Scoreboard monitor: every asserted Z write must match the head of the queue.
    always @(negedge clk) begin
        if (memz_we_o === 1'b1) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL zwrite_unexpected: got addr=%0d data=%04h, required no write",
                         memz_addr_o, memz_data_o);
            end else begin
                logic [ADDR_W+Z_W:0] e;
                e = exp_q.pop_front();
                if ({memz_addr_o, memz_data_o} !== e) begin
                    n_err++;
                    $display("FAIL zwrite: got addr=%0d data=%04h, required addr=%0d data=%04h",
                             memz_addr_o, memz_data_o, e[ADDR_W+Z_W:Z_W], e[Z_W-1:0]);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        init_i = 1'b0; clr_i = 1'b0; shift_i = 1'b0; convo_i = 1'b0;
        count_y_i = 1'b0; out_z_i = 1'b0; writez_i = 1'b0; count_h_i = 1'b0;
    endtask

    task automatic push_z(input int addr, input logic [Z_W-1:0] data);
        logic [ADDR_W:0] a;
        a = addr[ADDR_W:0];
        exp_q.push_back({a, data});
    endtask

    task automatic clear_mems();
        for (int i = 0; i < 32; i++) begin
            x_mem[i] = 8'd0;
            y_mem[i] = 8'd0;
        end
    endtask

    // FSM-like sequencing of a whole convolution run.
    task automatic run_conv(input logic [ADDR_W-1:0] sx, input logic [ADDR_W-1:0] sy,
                            input int nz, input string name);
        int outer;
        int inner;
        size_x_i = sx;
        size_y_i = sy;
        init_i = 1'b1;
        step();
        outer = 0;
        while (comp_hz_o === 1'b1 && outer < 70) begin
            clr_i = 1'b1;
            step();
            inner = 0;
            while (comp_yy_o === 1'b1 && inner < 40) begin
                shift_i = 1'b1;
                step();
                step();
                if (comp_shift_o === 1'b1) convo_i = 1'b1;
                count_y_i = 1'b1;
                step();
                inner++;
            end
            if (inner >= 40) check({name, "_tap_budget"}, 32'(inner), 32'd0);
            out_z_i = 1'b1;
            step();
            writez_i = 1'b1;
            step();
            count_h_i = 1'b1;
            step();
            outer++;
        end
        check({name, "_outputs"}, 32'(outer), 32'(nz));
        check({name, "_hz_low_at_end"}, 32'(comp_hz_o), 32'd0);
        check({name, "_queue_drained"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        rstn = 1'b0;
        init_i = 1'b0; clr_i = 1'b0; shift_i = 1'b0; convo_i = 1'b0;
        count_y_i = 1'b0; out_z_i = 1'b0; writez_i = 1'b0; count_h_i = 1'b0;
        size_x_i = 5'd0; size_y_i = 5'd0;
        clear_mems();
        repeat (2) @(posedge clk);
        #1;
        check("rst_we", 32'(memz_we_o), 32'd0);
        check("rst_zaddr", 32'(memz_addr_o), 32'd0);
        check("rst_zdata", 32'(memz_data_o), 32'd0);
        check("rst_hz", 32'(comp_hz_o), 32'd0);
        check("rst_yy", 32'(comp_yy_o), 32'd0);
        check("rst_shift", 32'(comp_shift_o), 32'd0);
        check("rst_xaddr", 32'(memx_addr_o), 32'd0);
        check("rst_yaddr", 32'(memy_addr_o), 32'd0);
        rstn = 1'b1;
        step();

        // Basic run: X={1,2,3}, Y={1,1} -> Z={1,3,5,3}
        x_mem[0] = 8'd1; x_mem[1] = 8'd2; x_mem[2] = 8'd3;
        y_mem[0] = 8'd1; y_mem[1] = 8'd1;
        push_z(0, 16'd1); push_z(1, 16'd3); push_z(2, 16'd5); push_z(3, 16'd3);
        run_conv(5'd3, 5'd2, 4, "basic");

        // All-255 run, sizes 4/4 -> tap counts 1,2,3,4,3,2,1
        clear_mems();
        for (int i = 0; i < 4; i++) begin
            x_mem[i] = 8'd255;
            y_mem[i] = 8'd255;
        end
`ifdef CONV_DP_SAT_EN
        push_z(0, 16'hFE01); push_z(1, 16'hFFFF); push_z(2, 16'hFFFF); push_z(3, 16'hFFFF);
        push_z(4, 16'hFFFF); push_z(5, 16'hFFFF); push_z(6, 16'hFE01);
`else
        push_z(0, 16'hFE01); push_z(1, 16'hFC02); push_z(2, 16'hFA03); push_z(3, 16'hF804);
        push_z(4, 16'hFA03); push_z(5, 16'hFC02); push_z(6, 16'hFE01);
`endif
        run_conv(5'd4, 5'd4, 7, "max");

        // Zero-size run: no writes expected at all
        run_conv(5'd0, 5'd3, 0, "zero");

        // Boundary taps on X={1,2,3}, Y={1,1}
        clear_mems();
        x_mem[0] = 8'd1; x_mem[1] = 8'd2; x_mem[2] = 8'd3;
        y_mem[0] = 8'd1; y_mem[1] = 8'd1;
        size_x_i = 5'd3; size_y_i = 5'd2;
        init_i = 1'b1;
        step();
        check("bnd_hz_after_init", 32'(comp_hz_o), 32'd1);
        clr_i = 1'b1;
        step();
        count_y_i = 1'b1;
        step();
        shift_i = 1'b1;
        step();
        check("bnd_h0j1_shift", 32'(comp_shift_o), 32'd0);
        check("bnd_h0j1_yaddr", 32'(memy_addr_o), 32'd1);
        check("bnd_h0j1_xaddr", 32'(memx_addr_o), 32'd31);
        step();
        out_z_i = 1'b1;
        step();
        push_z(0, 16'd0);
        writez_i = 1'b1;
        step();
        for (int i = 0; i < 3; i++) begin
            count_h_i = 1'b1;
            step();
        end
        shift_i = 1'b1;
        step();
        check("bnd_hlast_jlast_shift", 32'(comp_shift_o), 32'd1);
        check("bnd_hlast_jlast_xaddr", 32'(memx_addr_o), 32'd2);
        check("bnd_hlast_jlast_yaddr", 32'(memy_addr_o), 32'd1);

        // Reset asserted while a Z write is being presented
        size_x_i = 5'd3; size_y_i = 5'd2;
        init_i = 1'b1;
        step();
        clr_i = 1'b1;
        step();
        shift_i = 1'b1;
        step();
        step();
        convo_i = 1'b1; count_y_i = 1'b1;
        step();
        out_z_i = 1'b1;
        step();
        check("mid_hz_before_rst", 32'(comp_hz_o), 32'd1);
        check("mid_shift_before_rst", 32'(comp_shift_o), 32'd1);
        writez_i = 1'b1;
        rstn = 1'b0;
        #1;
        check("mid_rst_we", 32'(memz_we_o), 32'd0);
        check("mid_rst_hz", 32'(comp_hz_o), 32'd0);
        check("mid_rst_yy", 32'(comp_yy_o), 32'd0);
        check("mid_rst_shift", 32'(comp_shift_o), 32'd0);
        check("mid_rst_zdata", 32'(memz_data_o), 32'd0);
        step();
        rstn = 1'b1;
        step();
        push_z(0, 16'd1); push_z(1, 16'd3); push_z(2, 16'd5); push_z(3, 16'd3);
        run_conv(5'd3, 5'd2, 4, "after_rst");

        // init with clr, count_h, count_y and convo in the same cycle: init wins
        init_i = 1'b1; clr_i = 1'b1; count_h_i = 1'b1; count_y_i = 1'b1; convo_i = 1'b1;
        size_x_i = 5'd3; size_y_i = 5'd2;
        step();
        check("prio_hz", 32'(comp_hz_o), 32'd1);
        check("prio_yy", 32'(comp_yy_o), 32'd1);
        check("prio_shift", 32'(comp_shift_o), 32'd0);
        out_z_i = 1'b1;
        step();
        push_z(0, 16'd0);
        writez_i = 1'b1;
        step();
        check("prio_queue_drained", 32'(exp_q.size()), 32'd0);

        step();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/convolution_processor_datapath.md
# convolution_processor_datapath

Arithmetic and addressing datapath driven by the convolution processor FSM. Holds the output-index counter (H) and the tap counter (Y), computes X/Y memory read addresses, accumulates products, and writes each finished output sample to Z memory. It returns the three comparison flags that steer the FSM. It is the stage directly downstream of the FSM's control outputs.

## Interface
- DATA_W, 8, width of X and Y samples (unsigned)
- ADDR_W, 5, X/Y memory address width; sizes range 0..2^ADDR_W-1
- Z_W, 16, width of the written Z sample
- clk  in  1  clock; all state changes on rising edge
- rstn  in  1  reset, asynchronous, active-low
- init_i, clr_i, shift_i, convo_i, count_y_i, out_z_i, writez_i, count_h_i  in  1 each  FSM control strobes
- size_x_i  in  ADDR_W  number of X samples; sampled on init_i
- size_y_i  in  ADDR_W  number of Y samples; sampled on init_i
- comp_hz_o  out  1  h < size_z (more outputs to produce)
- comp_yy_o  out  1  j < size_y (more taps for current output)
- comp_shift_o  out  1  current tap addresses a valid X sample
- memx_addr_o  out  ADDR_W  X read address
- memx_data_i  in  DATA_W  X read data, 1-cycle synchronous latency
- memy_addr_o  out  ADDR_W  Y read address
- memy_data_i  in  DATA_W  Y read data, 1-cycle synchronous latency
- memz_addr_o  out  ADDR_W+1  Z write address
- memz_data_o  out  Z_W  Z write data
- memz_we_o  out  1  Z write enable

## Operation
- Computes z[h] = sum over j of y[j]·x[h−j], for 0 ≤ h < size_z.
- size_z = size_x + size_y − 1 (ADDR_W+1 bits). It is forced to 0 if either size is 0.
- Registers: size_x, size_y, size_z, h (ADDR_W+1), j (ADDR_W+1), acc (ACC_W = 2·DATA_W+ADDR_W+1), z_reg (Z_W), memx_addr, memy_addr, shift_ok.
- init_i: latch sizes and compute size_z; clear h, j, acc, z_reg, shift_ok.
- clr_i: clear j and acc.
- shift_i: memy_addr ← j[ADDR_W-1:0] and memx_addr ← (h−j) truncated. shift_ok ← (h ≥ j) && (h−j < size_x).
- convo_i: acc ← acc + memx_data_i·memy_data_i, with a full-width product.
- count_y_i: j ← j+1.
- out_z_i: z_reg ← acc reduced to Z_W (see Configuration).
- writez_i: memz_we_o = 1, memz_addr_o = h, memz_data_o = z_reg. These outputs are combinational from writez_i and registers.
- count_h_i: h ← h+1.
- Flags:
  - comp_hz_o = (h < size_z), combinational from registers.
  - comp_yy_o = (j < size_y), combinational from registers.
  - comp_shift_o = shift_ok.
- Priority if strobes coincide: init > clr > all others. Non-conflicting strobes act together, e.g. convo_i with count_y_i.
- Counters never wrap in normal use: j ≤ size_y and h ≤ size_z by construction. Wrap at counter width is otherwise unchecked.
- Strobes outside a run only modify registers; no memory write occurs unless writez_i is high.

## Timing
- Reset (asynchronous, rstn low): every register clears to 0. Consequently:
  - memz_we_o = 0 and all addresses/data = 0.
  - comp_hz_o = 0, comp_yy_o = 0, comp_shift_o = 0.
- Reset mid-run: outputs clear immediately. Any in-progress Z write is aborted. A new run needs init_i.
- Addresses written on shift_i are driven from the next cycle. Read data is valid the cycle after that, so the FSM gap shift → compare → convo meets the 1-cycle memory latency.
- comp_shift_o is valid the cycle after shift_i.
- comp_yy_o and comp_hz_o reflect count_y_i and count_h_i one cycle after the strobe.
- z_reg is valid the cycle after out_z_i. writez_i must follow out_z_i by at least 1 cycle.
- Write latency: memz_we_o rises in the same cycle as writez_i.
- Zero-size run: after init_i, comp_hz_o = 0, so the FSM finishes with no Z writes.

## Configuration
- CONV_DP_SAT_EN defined: out_z_i loads min(acc, 2^Z_W−1), i.e. unsigned saturation.
- Not defined: out_z_i loads acc[Z_W-1:0], i.e. truncation with no overflow indication.

## Test plan
- X={1,2,3}, Y={1,1}, full FSM-sequenced run → writes Z[0..3] = {1,3,5,3}; comp_hz_o falls after count_h_i for h=3.
- X={255,255,255,255}, Y={255,255,255,255}:
  - with CONV_DP_SAT_EN → Z[3] = 0xFFFF;
  - without → Z[3] = 0xF804 (260100 mod 65536);
  - in both builds Z[0] = 0xFE01.
- size_x=0, size_y=3, init_i → comp_hz_o=0 next cycle; memz_we_o never asserts.
- Boundary taps at h=0, j=1 → comp_shift_o=0 and acc unchanged. At h=size_z−1, j=size_y−1 → comp_shift_o=1 with memx_addr_o = size_x−1.
- rstn pulsed low while writez_i is high mid-run → memz_we_o drops immediately and all flags = 0. A fresh init run then produces correct Z.
- init_i and clr_i asserted in the same cycle as count_h_i → h=0, j=0, acc=0; init wins.
